// File: rtl/debam_eval_ctrl_pkg.sv
// debam_eval_ctrl_pkg: states, LFSR constants and per-sample percent width shared by the accuracy sequencer
package debam_eval_ctrl_pkg;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int PCT_W = 23;
  typedef enum logic [3:0] {IDLE, LOAD, SETTLE, MUL, CHECK, DIV_PCT, ACC, DIV_EFF, FINISH} state_t;
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/debam_eval_ctrl_div.sv
// debam_eval_ctrl_div: restoring divider, one quotient bit per cycle over DIV_W cycles; x/0 yields all ones
module debam_eval_ctrl_div #(
  parameter int DIV_W = 40,
  parameter int Q_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);
  localparam int CW = $clog2(DIV_W + 1);
  logic [DIV_W-1:0] rem, dvs, qr, rem_src, q_src, dvs_src, rem_nxt;
  logic [DIV_W:0] trial;
  logic [CW-1:0] cnt;
  logic ge;
  // the first iteration runs on the start edge so done lands in the DIV_W-th wait cycle
  always_comb begin
    rem_src = start ? '0 : rem;
    q_src = start ? dividend : qr;
    dvs_src = start ? divisor : dvs;
    trial = {rem_src, q_src[DIV_W-1]};
    ge = trial >= {1'b0, dvs_src};
    rem_nxt = ge ? DIV_W'(trial - {1'b0, dvs_src}) : trial[DIV_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      dvs <= '0;
      qr <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      done <= start ? (DIV_W == 1) : (cnt == CW'(1));
      if (start || cnt != '0) begin
        rem <= rem_nxt;
        qr <= {q_src[DIV_W-2:0], ge};
        dvs <= dvs_src;
        cnt <= start ? CW'(DIV_W - 1) : cnt - CW'(1);
      end
    end
  assign quotient = qr[Q_W-1:0];
endmodule

// File: rtl/debam_eval_ctrl.sv
// debam_eval_ctrl: drives the external approximate multiplier and reports mean accuracy percent over SAMPLES pairs
module debam_eval_ctrl
  import debam_eval_ctrl_pkg::*;
#(
  parameter int SAMPLES = 100,
  parameter int DIV_W = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op_mode,
  input  logic [15:0] seed,
  input  logic [7:0]  fixed_a,
  input  logic [7:0]  fixed_b,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_q,
  output logic        busy,
  output logic        done,
  output logic [23:0] eff
);
  state_t state, state_nxt;
  logic [15:0] lfsr, p, s, cnt, cnt_nxt;
  logic [2:0] k;
  logic [PCT_W-1:0] pct;
  logic [38:0] sum, sum_nxt;
  logic last, div_start, div_done;
  logic [DIV_W-1:0] div_dvd, div_dvs;
  logic [23:0] div_q;
  debam_eval_ctrl_div #(.DIV_W(DIV_W), .Q_W(24)) u_div (
    .clk(clk), .rst_n(rst_n), .start(div_start), .dividend(div_dvd),
    .divisor(div_dvs), .quotient(div_q), .done(div_done)
  );
  always_comb begin
    cnt_nxt = cnt + 16'd1;
    sum_nxt = sum + 39'(pct);
    last = cnt_nxt == 16'(SAMPLES);
    div_start = 1'b0;
    div_dvd = DIV_W'(p) * DIV_W'(100);
    div_dvs = DIV_W'(s);
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (SAMPLES == 0 ? FINISH : LOAD) : IDLE;
      LOAD:    state_nxt = SETTLE;
      SETTLE:  state_nxt = MUL;
      MUL:     state_nxt = k == 3'd7 ? CHECK : MUL;
      CHECK: begin
        div_start = p != s && s != '0;
        state_nxt = div_start ? DIV_PCT : ACC;
      end
      DIV_PCT: state_nxt = div_done ? ACC : DIV_PCT;
      ACC: begin
        div_start = last;
        div_dvd = DIV_W'(sum_nxt);
        div_dvs = DIV_W'(cnt_nxt);
        state_nxt = last ? DIV_EFF : LOAD;
      end
      DIV_EFF: state_nxt = div_done ? FINISH : DIV_EFF;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign done = state == FINISH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
      mul_a <= '0;
      mul_b <= '0;
      p <= '0;
      s <= '0;
      k <= '0;
      pct <= '0;
      sum <= '0;
      cnt <= '0;
      eff <= '0;
      busy <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          lfsr <= seed == '0 ? LFSR_SEED : seed;
          sum <= '0;
          cnt <= '0;
          eff <= '0;
          busy <= 1'b1;
        end
        LOAD: if (!op_mode) begin
          lfsr <= lfsr_step(lfsr);
          {mul_a, mul_b} <= lfsr_step(lfsr);
        end else begin
          mul_a <= fixed_a;
          mul_b <= fixed_b;
        end
        SETTLE: begin
          p <= mul_q;
          s <= '0;
          k <= '0;
        end
        MUL: begin
          s <= s + (mul_b[k] ? 16'(mul_a) << k : 16'd0);
          k <= k + 3'd1;
        end
        CHECK:   pct <= p == s ? PCT_W'(100) : '0;
        DIV_PCT: if (div_done) pct <= div_q[PCT_W-1:0];
        ACC: begin
          sum <= sum_nxt;
          cnt <= cnt_nxt;
        end
        DIV_EFF: if (div_done) eff <= div_q;
        FINISH:  busy <= 1'b0;
        default: ;
      endcase
endmodule

// File: doc/debam_eval_ctrl.md
Name: debam_eval_ctrl

Overview:
- Sequencer that exercises the 8x8 approximate multiplier (debam) in hardware and measures its accuracy on chip.
- Per sample: issues operand pairs, captures the approximate product, computes the exact product sequentially and derives a per-sample accuracy percentage.
- Reports the integer mean accuracy over SAMPLES operand pairs.
- Sits beside the multiplier instance; the multiplier stays combinational and external.

Parameters:
- SAMPLES, 100, number of operand pairs per run (16-bit range).
- DIV_W, 40, width of the shared sequential divider.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle run request; ignored while busy
- op_mode  input  1  operand source: 0 = LFSR, 1 = fixed_a/fixed_b
- seed  input  16  LFSR seed, sampled on accepted start
- fixed_a  input  8  fixed operand a (op_mode=1)
- fixed_b  input  8  fixed operand b (op_mode=1)
- mul_a  output  8  operand a to multiplier
- mul_b  output  8  operand b to multiplier
- mul_q  input  16  approximate product from multiplier
- busy  output  1  high from the cycle after start until done
- done  output  1  one-cycle pulse when eff is valid
- eff  output  24  mean accuracy percent, held until next accepted start

Behaviour:
- Async reset (rst_n=0): all outputs 0, FSM in IDLE, lfsr=16'hACE1, accumulators cleared. Reset mid-run aborts the run immediately, with no done pulse.
- Accepted start (IDLE and start=1):
  - lfsr<=seed; seed 0 is replaced by 16'hACE1.
  - sum<=0, cnt<=0, eff<=0.
  - busy<=1.
  - Next state: LOAD, or FINISH if SAMPLES==0.
- FSM states: IDLE, LOAD, SETTLE, MUL, CHECK, DIV_PCT, ACC, DIV_EFF, FINISH.
- LOAD (1 cycle):
  - op_mode=0: lfsr steps once (Fibonacci, taps 16,14,13,11; new bit shifted into LSB), then {mul_a,mul_b}<=stepped value.
  - op_mode=1: mul_a<=fixed_a, mul_b<=fixed_b.
- SETTLE (1 cycle): p<=mul_q, captured with operands stable for a full cycle.
- MUL (8 cycles): shift-add exact product s = mul_a*mul_b, 16 bits, one multiplier bit per cycle, LSB first.
- CHECK (1 cycle):
  - p==s: pct=100, go to ACC.
  - else s==0: pct=0, go to ACC.
  - else: start divider with dividend p*100 (zero-extended to DIV_W) and divisor s; go to DIV_PCT.
- DIV_PCT: wait for divider done (DIV_W cycles); pct = quotient, truncated. pct may exceed 100 (max 6553500, 23 bits).
- ACC (1 cycle):
  - sum<=sum+pct (39 bits, no overflow at SAMPLES<=65535); cnt<=cnt+1.
  - cnt+1==SAMPLES: start divider with sum/cnt+1, go to DIV_EFF.
  - else: go to LOAD.
- DIV_EFF: on divider done, eff<=quotient[23:0]; go to FINISH.
- FINISH (1 cycle): done=1, busy<=0; back to IDLE. With SAMPLES==0, eff=0.
- Latency per sample: 12 cycles (hit or s==0), or 12+DIV_W cycles otherwise.
- Operands hold their last value in IDLE.
- start during busy: ignored, no queuing.
- op_mode and fixed_a/fixed_b are sampled every LOAD.

Decomposition:
- Shared package: FSM state encodings, LFSR default seed 16'hACE1, LFSR tap constant, per-sample percentage width (23).
- Natural sub-module: seq_divider, a restoring divider, 1 quotient bit per cycle, DIV_W cycles.
  - Ports: clk, rst_n, start, dividend, divisor, quotient, done.
  - Divide-by-zero returns all-ones; the controller never issues it.

Test Plan:
- Stub mul_q=mul_a*mul_b, op_mode=0, seed=16'h1234, SAMPLES=100 -> done after run, eff=100, busy low after done.
- op_mode=1, fixed_a=10, fixed_b=10, stub mul_q=50, SAMPLES=1 -> s=100, pct=50, eff=50.
- op_mode=1, fixed_a=10, fixed_b=10, stub mul_q=300, SAMPLES=4 -> eff=300 (over-estimate unclamped).
- op_mode=1, fixed_a=0, fixed_b=7, stub mul_q=5 -> s=0, pct=0, eff=0; stub mul_q=0 -> pct=100, eff=100.
- Alternate samples 100/50 (toggle stub between mul_q=100 and mul_q=50, fixed 10x10), SAMPLES=3 -> sum=250, eff=83 (truncated).
- Assert rst_n low during DIV_PCT of sample 2 -> outputs 0 same cycle, no done pulse; next start completes a normal run. Also: start pulsed while busy has no effect on cnt or the run.
